instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Hardware program loader: the writer side of the CPU's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles it into 32-bit little-endian instruction words.
- Zero-fills instruction memory, then writes the assembled words into it, holding the CPU in reset until loading finishes.
- Sits between a host byte source (UART/JTAG bridge or bench) and the instruction memory write port of the single-cycle CPU.

Parameters:
DEPTH, 32, number of 32-bit words in instruction memory
ADDR_W, 5, word-address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  asynchronous, active-high reset
start_i  input  1  one-cycle pulse; begins clear+load; honoured only in IDLE or DONE
byte_valid_i  input  1  byte_data_i valid
byte_data_i  input  8  program byte; first byte of each word is bits [7:0]
byte_ready_o  output  1  loader can accept a byte this cycle
im_we_o  output  1  instruction memory write enable
im_addr_o  output  ADDR_W  word address (byte address = im_addr_o<<2)
im_wdata_o  output  32  write data
busy_o  output  1  high in CLEAR, COLLECT and WRITE
done_o  output  1  high in DONE
trunc_o  output  1  DEPTH words loaded with no terminator word seen
words_loaded_o  output  ADDR_W+1  count of non-terminator words written
cpu_rst_n_o  output  1  active-low reset to the CPU (drives its rst_n); released only in DONE

Behaviour:
- Reset (asynchronous, rst_i=1):
  - State goes to IDLE.
  - byte_ready_o, im_we_o, busy_o, done_o and trunc_o are 0.
  - im_addr_o, im_wdata_o and words_loaded_o are 0.
  - cpu_rst_n_o is 0.
  - Byte lane counter and word pointer clear; any partial word is discarded.
- States: IDLE, CLEAR, COLLECT, WRITE, DONE.
- IDLE: all outputs at their reset values. start_i moves to CLEAR.
- CLEAR (DEPTH cycles):
  - Cycle k drives im_we_o=1, im_addr_o=k, im_wdata_o=0.
  - byte_ready_o=0 and cpu_rst_n_o=0.
  - After address DEPTH-1, go to COLLECT with word_ptr=0, lane=0, words_loaded_o=0 and trunc_o=0.
- COLLECT:
  - byte_ready_o=1. A byte is accepted when byte_valid_i && byte_ready_o.
  - An accepted byte goes into lane `lane` (bits [8*lane+7:8*lane]), then lane increments.
  - Gaps in byte_valid_i are allowed; lanes hold their values.
  - The cycle that accepts the 4th byte (lane=3) transitions to WRITE.
- WRITE (exactly 1 cycle):
  - byte_ready_o=0, im_we_o=1, im_addr_o=word_ptr, im_wdata_o=the assembled word.
  - Assembled word == 32'd0: it is the terminator. It is written (harmless), words_loaded_o is unchanged, go to DONE.
  - Otherwise words_loaded_o++ and word_ptr++.
    - If word_ptr was DEPTH-1, set trunc_o=1 and go to DONE.
    - Else go to COLLECT with lane=0.
- DONE:
  - done_o=1 and cpu_rst_n_o=1 (registered, glitch-free).
  - byte_ready_o=0; incoming bytes are not accepted.
  - trunc_o and words_loaded_o hold their values.
  - start_i re-enters CLEAR: cpu_rst_n_o drops to 0 the same cycle the state changes, and done_o=0.
- start_i while busy_o=1 is ignored.
- Throughput: 4 accepted bytes plus 1 WRITE cycle per word. Minimum 5 cycles per word with byte_valid_i held high.
- im_we_o is never high outside CLEAR and WRITE. im_addr_o never exceeds DEPTH-1.
- Reset mid-operation returns to IDLE immediately. Memory contents are left as-is, and cpu_rst_n_o=0 asynchronously.

Test Plan:
- Reset values: assert rst_i mid-cycle -> all outputs 0 at once, including cpu_rst_n_o=0; start_i pulse -> 32 CLEAR writes, addresses 0..31, data 0, then byte_ready_o=1.
- Normal load: bytes 13,00,21,4C, 0A,00,22,4C, then 00,00,00,00 -> mem[0]=32'h4C210013, mem[1]=32'h4C22000A, mem[2]=0; words_loaded_o=2, trunc_o=0, done_o=1, cpu_rst_n_o rises only after the terminator WRITE.
- Handshake stalls: byte_valid_i toggles 1,0,0,1,... across one word -> lane assembly is unchanged, exactly one WRITE, no byte lost or duplicated; byte_ready_o=0 during the WRITE cycle.
- Truncation (DEPTH=4): 16 non-zero bytes -> 4 writes at addresses 0..3, trunc_o=1, words_loaded_o=4, done_o=1; the 17th byte is not accepted (byte_ready_o=0).
- Restart/ignored start: start_i pulsed during COLLECT -> no effect; start_i in DONE -> cpu_rst_n_o=0 the next cycle, CLEAR rewrites all zeros, words_loaded_o=0.
- Reset mid-load: rst_i after 2 bytes of word 1 -> IDLE, busy_o=0, cpu_rst_n_o=0; a fresh start_i and load produces correct words with no stale lanes.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// Byte-stream intake and instruction-memory write port of the program loader.
// The host side drives start/bytes; the loader side drives ready and the write port.
interface instr_mem_loader_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        output start,
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );

    modport slave (
        input  start,
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Program loader: zero-fills instruction memory, then packs a little-endian
// byte stream into 32-bit words and writes them, holding the CPU in reset.
module instr_mem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    instr_mem_loader_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic              trunc,
    output logic [ADDR_W:0]   words_loaded,
    output logic              cpu_rst_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] word_ptr;
    logic [1:0]        lane;
    logic [31:0]       word;
    logic              launch;
    logic              accept;
    logic              word_zero;

    assign launch    = bus.start && (state == S_IDLE || state == S_DONE);
    assign accept    = (state == S_COLLECT) && bus.byte_valid;
    assign word_zero = (word == 32'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n        = state;
        bus.byte_ready = 1'b0;
        bus.im_we      = 1'b0;
        bus.im_addr    = '0;
        bus.im_wdata   = '0;
        busy           = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start) state_n = S_CLEAR;
            end
            S_CLEAR: begin
                busy        = 1'b1;
                bus.im_we   = 1'b1;
                bus.im_addr = clr_addr;
                if (clr_addr == LAST) state_n = S_COLLECT;
            end
            S_COLLECT: begin
                busy           = 1'b1;
                bus.byte_ready = 1'b1;
                if (bus.byte_valid && lane == 2'd3) state_n = S_WRITE;
            end
            S_WRITE: begin
                busy         = 1'b1;
                bus.im_we    = 1'b1;
                bus.im_addr  = word_ptr;
                bus.im_wdata = word;
                if (word_zero || word_ptr == LAST) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_COLLECT;
                end
            end
            S_DONE: begin
                if (bus.start) state_n = S_CLEAR;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // CPU reset release is registered so it cannot glitch on state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            done      <= (state_n == S_DONE);
            cpu_rst_n <= (state_n == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr     <= '0;
            word_ptr     <= '0;
            lane         <= '0;
            word         <= '0;
            words_loaded <= '0;
            trunc        <= 1'b0;
        end else if (launch) begin
            clr_addr     <= '0;
            word_ptr     <= '0;
            lane         <= '0;
            word         <= '0;
            words_loaded <= '0;
            trunc        <= 1'b0;
        end else begin
            if (state == S_CLEAR && clr_addr != LAST) begin
                clr_addr <= clr_addr + 1'b1;
            end
            if (accept) begin
                word[{lane, 3'b000} +: 8] <= bus.byte_data;
                lane                      <= lane + 2'd1;
            end
            if (state == S_WRITE && !word_zero) begin
                words_loaded <= words_loaded + (ADDR_W+1)'(1);
                word_ptr     <= word_ptr + 1'b1;
                if (word_ptr == LAST) trunc <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: table vectors, hand corner cases and random
// byte streams checked against a word-level loader model.
module tb_instr_mem_loader;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wrec_t;

    typedef struct {
        logic busy, done, trunc, crn, ready, we;
        int          addr;
        logic [31:0] wdata;
        int          wl;
    } obs_t;

    typedef struct {
        logic [127:0] bytes;
        int           n;
        int           gap;
        bit           poke;
        int           loaded;
        logic [31:0]  m0;
        logic [31:0]  m1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instr_mem_loader_if #(.ADDR_W(5)) i32 ();
    instr_mem_loader_if #(.ADDR_W(2)) i4 ();

    logic       busy32, done32, trunc32, crn32;
    logic [5:0] wl32;
    logic       busy4, done4, trunc4, crn4;
    logic [2:0] wl4;

    instr_mem_loader #(.DEPTH(32), .ADDR_W(5)) u32 (
        .clk(clk), .rst(rst), .bus(i32),
        .busy(busy32), .done(done32), .trunc(trunc32),
        .words_loaded(wl32), .cpu_rst_n(crn32)
    );

    instr_mem_loader #(.DEPTH(4), .ADDR_W(2)) u4 (
        .clk(clk), .rst(rst), .bus(i4),
        .busy(busy4), .done(done4), .trunc(trunc4),
        .words_loaded(wl4), .cpu_rst_n(crn4)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int viol     = 0;
    int cyc      = 0;
    wrec_t       wq32[$];
    wrec_t       wq4[$];
    logic [31:0] mem32[32];
    logic [31:0] mem4[4];

    // Instruction memory stand-ins plus a write log.
    always @(posedge clk) begin
        cyc++;
        if (i32.im_we === 1'b1) begin
            wq32.push_back('{int'(i32.im_addr), i32.im_wdata, cyc});
            mem32[i32.im_addr] = i32.im_wdata;
        end
        if (i4.im_we === 1'b1) begin
            wq4.push_back('{int'(i4.im_addr), i4.im_wdata, cyc});
            mem4[i4.im_addr] = i4.im_wdata;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (i32.im_we && (!busy32 || crn32)) viol++;
            if (crn32 !== done32) viol++;
            if (i32.byte_ready && i32.im_we) viol++;
            if (i4.im_we && (!busy4 || crn4)) viol++;
            if (crn4 !== done4) viol++;
            if (i4.byte_ready && i4.im_we) viol++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic obs_t obs(input bit s);
        obs_t o;
        if (s) begin
            o = '{busy4, done4, trunc4, crn4, i4.byte_ready, i4.im_we,
                  int'(i4.im_addr), i4.im_wdata, int'(wl4)};
        end else begin
            o = '{busy32, done32, trunc32, crn32, i32.byte_ready, i32.im_we,
                  int'(i32.im_addr), i32.im_wdata, int'(wl32)};
        end
        return o;
    endfunction

    task automatic drive(input bit s, input logic st, input logic v,
                         input logic [7:0] d);
        if (s) begin
            i4.start = st; i4.byte_valid = v; i4.byte_data = d;
        end else begin
            i32.start = st; i32.byte_valid = v; i32.byte_data = d;
        end
    endtask

    // Loader model: little-endian words, stop at a zero word or a full memory.
    function automatic void model(input logic [7:0] b[$], input int depth,
                                  output wrec_t ex[$], output int loaded,
                                  output bit tr);
        logic [31:0] w;
        ex = {};
        loaded = 0;
        tr = 0;
        for (int i = 0; 4 * i + 3 < b.size(); i++) begin
            w = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
            ex.push_back('{i, w, 0});
            if (w == 32'd0) break;
            loaded++;
            if (i == depth - 1) begin
                tr = 1;
                break;
            end
        end
    endfunction

    task automatic feed(input bit s, input logic [7:0] b[$], input int n,
                        input int maxgap);
        int   tries;
        int   g;
        obs_t o;
        for (int j = 0; j < n; j++) begin
            g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            repeat (g) begin
                @(negedge clk);
                drive(s, 1'b0, 1'b0, 8'h00);
            end
            tries = 0;
            o.ready = 1'b0;
            while (!o.ready && tries < 100) begin
                @(negedge clk);
                drive(s, 1'b0, 1'b1, b[j]);
                o = obs(s);
                tries++;
            end
            if (!o.ready) begin
                chk("byte_accept_timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic pulse_start(input bit s);
        @(negedge clk);
        drive(s, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        drive(s, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic run_load(input bit s, input logic [7:0] b[$],
                            input int maxgap, input bit poke);
        int          depth;
        wrec_t       ex[$];
        wrec_t       got[$];
        int          loaded;
        bit          tr;
        obs_t        o;
        int          t;
        int          bad;
        logic [31:0] em[32];
        logic [31:0] gm;
        depth = s ? 4 : 32;
        model(b, depth, ex, loaded, tr);
        if (s) wq4.delete(); else wq32.delete();
        pulse_start(s);
        o = obs(s);
        chk("start_busy", o.busy, 1);
        chk("start_we", o.we, 1);
        chk("start_addr", o.addr, 0);
        chk("start_cpu_rst_n", o.crn, 0);
        chk("start_done", o.done, 0);
        chk("start_loaded", o.wl, 0);
        if (poke) begin
            t = 0;
            while (!o.ready && t < 100) begin
                @(negedge clk);
                o = obs(s);
                t++;
            end
            chk("poke_ready", o.ready, 1);
            pulse_start(s);
            o = obs(s);
            chk("poke_ignored_we", o.we, 0);
            chk("poke_ignored_busy", o.busy, 1);
        end
        feed(s, b, 4 * ex.size(), maxgap);
        @(negedge clk);
        drive(s, 1'b0, 1'b0, 8'h00);
        t = 0;
        o = obs(s);
        while (!o.done && t < 40) begin
            @(negedge clk);
            o = obs(s);
            t++;
        end
        chk("done", o.done, 1);
        chk("cpu_rst_n", o.crn, 1);
        chk("busy_in_done", o.busy, 0);
        chk("ready_in_done", o.ready, 0);
        chk("words_loaded", o.wl, loaded);
        chk("trunc", o.trunc, tr);
        if (s) got = wq4; else got = wq32;
        chk("write_count", got.size(), depth + ex.size());
        bad = 0;
        for (int k = 0; k < depth && k < got.size(); k++) begin
            if (got[k].addr != k || got[k].data != 32'd0) bad++;
        end
        chk("clear_writes", bad, 0);
        for (int i = 0; i < ex.size() && depth + i < got.size(); i++) begin
            chk("load_addr", got[depth+i].addr, ex[i].addr);
            chk("load_data", got[depth+i].data, ex[i].data);
            if (maxgap == 0 && i > 0) begin
                chk("word_interval", got[depth+i].cyc - got[depth+i-1].cyc, 5);
            end
        end
        for (int k = 0; k < 32; k++) em[k] = 32'd0;
        foreach (ex[i]) em[ex[i].addr] = ex[i].data;
        for (int k = 0; k < depth; k++) begin
            if (s) gm = mem4[k]; else gm = mem32[k];
            chk("mem_word", gm, em[k]);
        end
    endtask

    initial begin
        vec_t        vt[4];
        logic [7:0]  q[$];
        logic [31:0] w;
        obs_t        o;
        int          nw;
        int          nwr;

        vt[0] = '{128'h00000000_00000000_4C22000A_4C210013, 12, 0, 0, 2,
                  32'h4C210013, 32'h4C22000A};
        vt[1] = '{128'h00000000_00000000_00000000_DDCCBBAA, 8, 2, 0, 1,
                  32'hDDCCBBAA, 32'h00000000};
        vt[2] = '{128'h0, 4, 0, 0, 0, 32'h0, 32'h0};
        vt[3] = '{128'h00000000_00000000_01000000_00000100, 12, 1, 1, 2,
                  32'h00000100, 32'h01000000};

        drive(0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            o = obs(s[0]);
            chk("rst_busy", o.busy, 0);
            chk("rst_done", o.done, 0);
            chk("rst_trunc", o.trunc, 0);
            chk("rst_ready", o.ready, 0);
            chk("rst_we", o.we, 0);
            chk("rst_addr", o.addr, 0);
            chk("rst_wdata", o.wdata, 0);
            chk("rst_loaded", o.wl, 0);
            chk("rst_cpu_rst_n", o.crn, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 8'h77);
        @(negedge clk);
        o = obs(0);
        chk("idle_ready", o.ready, 0);
        chk("idle_busy", o.busy, 0);
        drive(0, 1'b0, 1'b0, 8'h00);

        foreach (vt[v]) begin
            q = {};
            for (int k = 0; k < vt[v].n; k++) q.push_back(vt[v].bytes[8*k +: 8]);
            run_load(0, q, vt[v].gap, vt[v].poke);
            chk("tbl_loaded", wl32, vt[v].loaded);
            chk("tbl_m0", mem32[0], vt[v].m0);
            chk("tbl_m1", mem32[1], vt[v].m1);
        end

        // Reset mid-load with a half-assembled second word.
        q = {8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB};
        pulse_start(0);
        feed(0, q, 6, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        o = obs(0);
        chk("midrst_busy", o.busy, 0);
        chk("midrst_ready", o.ready, 0);
        chk("midrst_we", o.we, 0);
        chk("midrst_cpu_rst_n", o.crn, 0);
        chk("midrst_loaded", o.wl, 0);
        drive(0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        q = {8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
        run_load(0, q, 0, 0);
        chk("midrst_word", mem32[0], 32'h0A0B0C0D);

        // Truncation on the 4-word instance, then a 17th byte must stall.
        q = {};
        for (int k = 0; k < 16; k++) q.push_back(8'(k + 1));
        run_load(1, q, 0, 0);
        chk("trunc4_flag", trunc4, 1);
        chk("trunc4_loaded", wl4, 4);
        chk("trunc4_m3", mem4[3], 32'h100F0E0D);
        nwr = wq4.size();
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 8'h55);
        o = obs(1);
        chk("byte17_ready", o.ready, 0);
        repeat (3) @(negedge clk);
        chk("byte17_no_write", wq4.size(), nwr);
        chk("byte17_done", done4, 1);
        drive(1, 1'b0, 1'b0, 8'h00);

        for (int r = 0; r < 11; r++) begin
            nw = (r < 8) ? $urandom_range(0, 6) : $urandom_range(2, 6);
            q = {};
            for (int i = 0; i < nw; i++) begin
                w = $urandom;
                if ($urandom_range(0, 3) == 0) w[15:8] = 8'h00;
                if (w == 32'd0) w = 32'h1;
                for (int k = 0; k < 4; k++) q.push_back(w[8*k +: 8]);
            end
            for (int k = 0; k < 4; k++) q.push_back(8'h00);
            run_load(r >= 8, q, $urandom_range(0, 2), 1'b0);
        end

        chk("invariants", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
